// File: rtl/otter_intr_pkg.sv
// rtl/otter_intr_pkg.sv - shared FSM state and register address definitions for otter_intr_ctrl
package otter_intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } intr_state_e;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

endpackage

// File: rtl/otter_sync.sv
// rtl/otter_sync.sv - WIDTH-wide, STAGES-deep flop-chain synchronizer
module otter_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/otter_intr_ctrl.sv
// rtl/otter_intr_ctrl.sv - prioritized interrupt controller with level/edge channels and a
// three-state handshake toward the CU FSM
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] IRQ_IN,
  input  logic            CFG_WE,
  input  logic [1:0]      CFG_ADDR,
  input  logic [31:0]     CFG_WD,
  output logic [31:0]     CFG_RD,
  output logic            INTR,
  output logic [ID_W-1:0] INT_ID,
  input  logic            INT_TAKEN,
  input  logic            INT_DONE
);

  logic [N_CH-1:0] irq_sync;
  logic [N_CH-1:0] hist_q;
  logic [N_CH-1:0] enable_q;
  logic [N_CH-1:0] mode_q;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] cand;
  logic [N_CH-1:0] clr;
  logic [ID_W-1:0] int_id_q, int_id_d;
  logic [ID_W-1:0] winner;
  logic [31:0]     status;
  logic            take_ok;
  logic            unused_wd;
  intr_state_e     state_q, state_d;

  otter_sync #(
    .WIDTH (N_CH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(CLK),
    .rst_i(RST),
    .d_i  (IRQ_IN),
    .q_o  (irq_sync)
  );

  assign rise    = irq_sync & ~hist_q;
  assign cand    = pend_q & enable_q;
  assign take_ok = (state_q == ST_ASSERT) && INT_TAKEN;
  assign unused_wd = ^CFG_WD;

  always_comb begin
    clr = '0;
    if (CFG_WE && (CFG_ADDR == ADDR_PENDING)) begin
      clr = CFG_WD[N_CH-1:0];
    end
    if (take_ok) begin
      clr[int_id_q] = 1'b1;
    end
  end

  // Level channels are registered as well so both modes see the same request latency.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (mode_q[i]) begin
        pend_d[i] = rise[i] | (pend_q[i] & ~clr[i]);
      end else begin
        pend_d[i] = irq_sync[i];
      end
    end
  end

  always_comb begin
    winner = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    int_id_d = int_id_q;
    case (state_q)
      ST_IDLE: begin
        if (|cand) begin
          state_d  = ST_ASSERT;
          int_id_d = winner;
        end
      end
      ST_ASSERT: begin
        if (INT_TAKEN) begin
          state_d = ST_SERVICE;
        end else if (!cand[int_id_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (INT_DONE) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hist_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      state_q  <= ST_IDLE;
      int_id_q <= '0;
    end else begin
      hist_q   <= irq_sync;
      pend_q   <= pend_d;
      state_q  <= state_d;
      int_id_q <= int_id_d;
      if (CFG_WE && (CFG_ADDR == ADDR_ENABLE)) begin
        enable_q <= CFG_WD[N_CH-1:0];
      end
      if (CFG_WE && (CFG_ADDR == ADDR_MODE)) begin
        mode_q <= CFG_WD[N_CH-1:0];
      end
    end
  end

  assign INTR   = (state_q == ST_ASSERT);
  assign INT_ID = int_id_q;

  always_comb begin
    status           = '0;
    status[0]        = INTR;
    status[2:1]      = state_q;
    status[8 +: ID_W] = int_id_q;
  end

  always_comb begin
    CFG_RD = '0;
    case (CFG_ADDR)
      ADDR_ENABLE:  CFG_RD = 32'(enable_q);
      ADDR_MODE:    CFG_RD = 32'(mode_q);
      ADDR_PENDING: CFG_RD = 32'(pend_q);
      default:      CFG_RD = status;
    endcase
  end

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb/tb_otter_intr_ctrl.sv - directed self-checking bench for otter_intr_ctrl
module tb_otter_intr_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  IRQ_IN;
  logic        CFG_WE;
  logic [1:0]  CFG_ADDR;
  logic [31:0] CFG_WD;
  logic [31:0] CFG_RD;
  logic        INTR;
  logic [2:0]  INT_ID;
  logic        INT_TAKEN;
  logic        INT_DONE;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [1:0]  rd_addr;
    logic [31:0] exp;
  } cfg_vec_t;

  cfg_vec_t vecs[7];

  otter_intr_ctrl #(.N_CH(8), .SYNC_STAGES(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IRQ_IN   (IRQ_IN),
    .CFG_WE   (CFG_WE),
    .CFG_ADDR (CFG_ADDR),
    .CFG_WD   (CFG_WD),
    .CFG_RD   (CFG_RD),
    .INTR     (INTR),
    .INT_ID   (INT_ID),
    .INT_TAKEN(INT_TAKEN),
    .INT_DONE (INT_DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    CFG_WE = 1'b1; CFG_ADDR = a; CFG_WD = d;
    tick();
    CFG_WE = 1'b0; CFG_WD = '0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] v);
    CFG_ADDR = a;
    #1;
    v = CFG_RD;
  endtask

  task automatic do_reset();
    RST = 1'b1; IRQ_IN = '0; CFG_WE = 1'b0; CFG_ADDR = 2'd0; CFG_WD = '0;
    INT_TAKEN = 1'b0; INT_DONE = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic pulse_taken();
    INT_TAKEN = 1'b1; tick(); INT_TAKEN = 1'b0;
  endtask

  task automatic pulse_done();
    INT_DONE = 1'b1; tick(); INT_DONE = 1'b0;
  endtask

  task automatic wait_intr(input string name, output int n);
    n = 0;
    while (!INTR && n < 12) begin
      tick();
      n++;
    end
    check({name, " intr_timeout"}, 32'(INTR), 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    int n;
    int highs;

    vecs[0] = '{1'b1, 2'd0, 32'hFFFF_FFA5, 2'd0, 32'h0000_00A5};
    vecs[1] = '{1'b1, 2'd1, 32'h1234_5603, 2'd1, 32'h0000_0003};
    vecs[2] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
    vecs[3] = '{1'b0, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_00A5};
    vecs[4] = '{1'b1, 2'd2, 32'h0000_00FF, 2'd2, 32'h0000_0000};
    vecs[5] = '{1'b1, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
    vecs[6] = '{1'b1, 2'd1, 32'h0000_0000, 2'd1, 32'h0000_0000};

    do_reset();
    check("rst intr", 32'(INTR), 32'd0);
    check("rst int_id", 32'(INT_ID), 32'd0);
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), v);
      check($sformatf("rst reg%0d", a), v, 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      CFG_WE = vecs[i].we; CFG_ADDR = vecs[i].addr; CFG_WD = vecs[i].wd;
      tick();
      CFG_WE = 1'b0; CFG_WD = '0;
      cfg_read(vecs[i].rd_addr, v);
      check($sformatf("cfg vec%0d", i), v, vecs[i].exp);
    end

    // edge ch0, one-cycle pulse: INTR at edge 4
    do_reset();
    cfg_write(2'd1, 32'h01);
    cfg_write(2'd0, 32'h01);
    IRQ_IN = 8'h01;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 1) IRQ_IN = 8'h00;
      check($sformatf("lat edge%0d", e), 32'(INTR), (e == 4) ? 32'd1 : 32'd0);
    end
    check("edge0 id", 32'(INT_ID), 32'd0);
    cfg_read(2'd2, v);
    check("edge0 pend before take", v, 32'h01);
    pulse_taken();
    check("edge0 intr after take", 32'(INTR), 32'd0);
    cfg_read(2'd2, v);
    check("edge0 pend after take", v, 32'h00);
    cfg_read(2'd3, v);
    check("edge0 status service", v, 32'h0000_0004);
    pulse_done();
    cfg_read(2'd3, v);
    check("edge0 status idle", v, 32'h0000_0000);

    // priority: ch5 and ch2 together
    do_reset();
    cfg_write(2'd1, 32'hFF);
    cfg_write(2'd0, 32'hFF);
    IRQ_IN = 8'h24;
    wait_intr("prio first", n);
    check("prio latency", n, 32'd4);
    check("prio id2", 32'(INT_ID), 32'd2);
    pulse_taken();
    pulse_done();
    check("prio idle gap", 32'(INTR), 32'd0);
    tick();
    check("prio second intr", 32'(INTR), 32'd1);
    check("prio id5", 32'(INT_ID), 32'd5);
    pulse_taken();
    pulse_done();
    IRQ_IN = 8'h00;

    // level ch3 drops during ASSERT
    do_reset();
    cfg_write(2'd0, 32'h08);
    IRQ_IN = 8'h08;
    wait_intr("lvl", n);
    check("lvl id3", 32'(INT_ID), 32'd3);
    IRQ_IN = 8'h00;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("lvl hold edge%0d", e), 32'(INTR), 32'd1);
    end
    cfg_read(2'd2, v);
    check("lvl pend dropped", v, 32'h00);
    tick();
    check("lvl intr off", 32'(INTR), 32'd0);
    cfg_read(2'd3, v);
    check("lvl state idle", v & 32'h7, 32'h0);

    // no nesting in SERVICE
    do_reset();
    cfg_write(2'd0, 32'h03);
    IRQ_IN = 8'h02;
    wait_intr("nest", n);
    check("nest id1", 32'(INT_ID), 32'd1);
    pulse_taken();
    IRQ_IN = 8'h03;
    highs = 0;
    for (int e = 0; e < 6; e++) begin
      tick();
      if (INTR) highs++;
    end
    check("nest intr stayed low", highs, 32'd0);
    cfg_read(2'd3, v);
    check("nest status service", v, 32'h0000_0104);
    pulse_done();
    check("nest idle cycle", 32'(INTR), 32'd0);
    tick();
    check("nest intr after done", 32'(INTR), 32'd1);
    check("nest id0", 32'(INT_ID), 32'd0);
    pulse_taken();
    pulse_done();
    IRQ_IN = 8'h00;

    // W1C colliding with a new edge on ch4
    do_reset();
    cfg_write(2'd1, 32'h10);
    IRQ_IN = 8'h10;
    tick(); tick(); tick();
    IRQ_IN = 8'h00;
    tick(); tick(); tick(); tick();
    cfg_read(2'd2, v);
    check("w1c pend set", v, 32'h10);
    IRQ_IN = 8'h10;
    tick(); tick();
    cfg_write(2'd2, 32'h10);
    cfg_read(2'd2, v);
    check("w1c set wins", v, 32'h10);
    cfg_write(2'd2, 32'h10);
    cfg_read(2'd2, v);
    check("w1c clears", v, 32'h00);
    IRQ_IN = 8'h00;

    // reset during SERVICE
    do_reset();
    cfg_write(2'd0, 32'h01);
    IRQ_IN = 8'h01;
    wait_intr("rstsvc", n);
    pulse_taken();
    cfg_read(2'd3, v);
    check("rstsvc status service", v, 32'h0000_0004);
    RST = 1'b1; IRQ_IN = 8'h00;
    tick();
    check("rstsvc intr", 32'(INTR), 32'd0);
    cfg_read(2'd3, v);
    check("rstsvc status", v, 32'h0);
    cfg_read(2'd0, v);
    check("rstsvc enable", v, 32'h0);
    RST = 1'b0;
    pulse_done();
    tick();
    cfg_read(2'd3, v);
    check("rstsvc stale done", v, 32'h0);
    check("rstsvc intr after", 32'(INTR), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/otter_intr_ctrl.md
OTTER_INTR_CTRL -- requirements
Module: otter_intr_ctrl

Interface
REQ-001 SHALL provide parameter N_CH, default 8, number of interrupt channels (legal 1..32).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, synchronizer depth per channel (legal 2..4).
REQ-003 SHALL derive localparam ID_W = max(1, clog2(N_CH)), the channel-ID width.
REQ-004 SHALL have one clock; reset is synchronous and active-high, on ports CLK and RST.
REQ-005 CLK  input  1  system clock, all state on rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 IRQ_IN  input  N_CH  raw asynchronous interrupt requests.
REQ-008 CFG_WE  input  1  configuration write strobe.
REQ-009 CFG_ADDR  input  2  register select: 0 ENABLE, 1 MODE, 2 PENDING, 3 STATUS.
REQ-010 CFG_WD  input  32  configuration write data.
REQ-011 CFG_RD  output  32  combinational read data for CFG_ADDR.
REQ-012 INTR  output  1  interrupt request to CU FSM.
REQ-013 INT_ID  output  ID_W  index of the requesting or serviced channel.
REQ-014 INT_TAKEN  input  1  one-cycle pulse from CU FSM when the trap is entered.
REQ-015 INT_DONE  input  1  one-cycle pulse when MRET executes.

Function
REQ-016 Each IRQ_IN bit SHALL pass through a SYNC_STAGES-deep flop chain before any use.
REQ-017 MODE bit 0 = level: pending[i] SHALL equal the synchronized level.
REQ-018 MODE bit 1 = edge: pending[i] SHALL set on a synchronized rising edge and hold until cleared.
REQ-019 An edge pending bit SHALL clear on a CFG write of 1 to PENDING (write-1-to-clear), or on INT_TAKEN for channel INT_ID.
REQ-020 A simultaneous set and clear of the same edge pending bit SHALL leave the bit set.
REQ-021 The candidate set SHALL be pending & ENABLE; the lowest index SHALL have the highest priority.
REQ-022 FSM states SHALL be IDLE, ASSERT and SERVICE.
REQ-023 IDLE: a non-empty candidate set SHALL move the FSM to ASSERT on the next edge, latching the winner into INT_ID.
REQ-024 ASSERT: INTR=1 and INT_ID is frozen; a higher-priority arrival SHALL NOT preempt.
REQ-025 ASSERT: if INT_ID's candidate bit drops before INT_TAKEN, the FSM SHALL return to IDLE with INTR=0 on the next edge.
REQ-026 ASSERT with INT_TAKEN SHALL go to SERVICE; INTR is low from that edge onward.
REQ-027 SERVICE: INTR=0, INT_ID held, no nesting; INT_DONE SHALL return the FSM to IDLE.
REQ-028 INT_DONE SHALL be ignored outside SERVICE; INT_TAKEN SHALL be ignored outside ASSERT.
REQ-029 Latency: INTR SHALL rise exactly SYNC_STAGES+2 rising edges after the first edge sampling IRQ_IN high (enabled channel, IDLE).
REQ-030 CFG writes to addresses 0 and 1 SHALL take effect on the next edge; writes to 3 SHALL be ignored.
REQ-031 CFG_RD bits at or above N_CH in addresses 0-2 SHALL read 0.
REQ-032 STATUS SHALL read as: bit0 INTR, bits[2:1] state encoding, bits[8+ID_W-1:8] INT_ID, all other bits 0.

Reset
REQ-033 RST SHALL clear ENABLE, MODE (all level), pending, all synchronizer flops and the edge-history register.
REQ-034 RST SHALL force IDLE, INTR=0 and INT_ID=0 on the same edge, including mid-ASSERT or mid-SERVICE; in-flight requests are discarded.

Structure
REQ-035 Package otter_intr_pkg SHALL hold the state enum and the CFG address constants (ENABLE, MODE, PENDING, STATUS).
REQ-036 Sub-module otter_sync SHALL implement the parametrised WIDTH x STAGES synchronizer and be instantiated once.

Verification
REQ-037 Edge mode, ENABLE=0x01, pulse IRQ_IN[0] one cycle -> INTR high at edge 4 (SYNC_STAGES=2), INT_ID=0; INT_TAKEN clears PENDING bit0.
REQ-038 ENABLE=0xFF, IRQ_IN bits 5 and 2 rise together -> INT_ID=2; after INT_DONE, a second request with INT_ID=5 follows.
REQ-039 Level mode ch3, IRQ drops during ASSERT before INT_TAKEN -> INTR=0 next edge, FSM returns to IDLE, PENDING=0.
REQ-040 In SERVICE (ch1), raise ch0 -> INTR stays 0 until INT_DONE, then INTR rises with INT_ID=0 after one IDLE cycle.
REQ-041 W1C write 0x10 to PENDING on the same cycle as a new edge on ch4 -> bit4 remains 1.
REQ-042 Assert RST during SERVICE -> next edge: INTR=0, STATUS=0, ENABLE=0; the stale INT_DONE afterward has no effect.
